serial_tx_frame: RTL

Parametrised successor to the ADC serial sender: a UART-style transmitter that frames a DATA_BITS-wide word with a start bit, optional parity and one or two stop bits. Bit timing is generated internally from the system clock; no separate baud clock is needed. It sits between the ADC sample latch and the board TX pin. A valid/ready handshake replaces the enable-edge trigger.

---
 rtl/serial_pkg.sv | 22 ++
 rtl/serial_baud_gen.sv | 35 +++
 rtl/serial_tx_frame.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/serial_pkg.sv
// serial_pkg: shared types and default timing constants for the serial
// transmit/receive blocks.
//   state_t              - frame FSM states (PARITY only used when the
//                          SERIAL_TX_PARITY_EN build macro is defined)
//   SYS_CLK_HZ           - board system clock
//   BAUD_DEFAULT         - default line rate
//   CLKS_PER_BIT_DEFAULT - system clocks per serial bit at the default rate
package serial_pkg;

    localparam int SYS_CLK_HZ           = 50_000_000;
    localparam int BAUD_DEFAULT         = 115200;
    localparam int CLKS_PER_BIT_DEFAULT = SYS_CLK_HZ / BAUD_DEFAULT;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

endpackage

// File: rtl/serial_baud_gen.sv
// serial_baud_gen: bit-period counter for the serial blocks.
// Ports:
//   clk      in   system clock, rising edge
//   rst      in   asynchronous reset, active-high
//   clear    in   restart the bit period from zero
//   enable   in   count only while high; held at zero otherwise (idle hold-off)
//   bit_tick out  high on the last clock of each bit period
module serial_baud_gen #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic bit_tick
);

    localparam int            CW   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt;

    assign bit_tick = enable && (cnt == LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clear || !enable || bit_tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/serial_tx_frame.sv
// serial_tx_frame: UART-style transmitter. Frames a DATA_BITS-wide word with
// a start bit, optional parity bit and STOP_BITS stop bits; bit timing is
// derived from clk via serial_baud_gen.
// Build macro: SERIAL_TX_PARITY_EN inserts a parity bit after the data bits
// and adds parameter PARITY_ODD (0 = even, 1 = odd).
// Ports:
//   clk        in   system clock, rising edge
//   rst        in   asynchronous reset, active-high (release synchronous to clk)
//   tx_data    in   word to send, sampled on accept
//   tx_valid   in   tx_data is valid
//   tx_ready   out  word can be accepted (IDLE only)
//   tx         out  serial line, idle high
//   busy       out  frame in progress
//   frame_done out  one-cycle pulse after the last stop bit
module serial_tx_frame
    import serial_pkg::*;
#(
    parameter int DATA_BITS    = 8,
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
    parameter int STOP_BITS    = 1,
    parameter int LSB_FIRST    = 1
`ifdef SERIAL_TX_PARITY_EN
    ,
    parameter int PARITY_ODD   = 0
`endif
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 tx,
    output logic                 busy,
    output logic                 frame_done
);

    localparam int            BW        = $clog2(DATA_BITS + 1);
    localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_BITS - 1);
    localparam logic [BW-1:0] LAST_STOP = BW'(STOP_BITS - 1);

    state_t               state, state_n;
    logic [DATA_BITS-1:0] shreg, shreg_n;
    logic [BW-1:0]        bit_cnt, bit_cnt_n;
    logic                 done_n;
    logic                 bit_tick;
    logic                 accept;
    logic                 data_bit;
`ifdef SERIAL_TX_PARITY_EN
    logic                 par_bit, par_bit_n;
`endif

    assign tx_ready = (state == IDLE);
    assign busy     = !tx_ready;
    assign accept   = tx_valid && tx_ready;
    assign data_bit = (LSB_FIRST != 0) ? shreg[0] : shreg[DATA_BITS-1];

    serial_baud_gen #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk     (clk),
        .rst     (rst),
        .clear   (accept),
        .enable  (busy),
        .bit_tick(bit_tick)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            shreg      <= '0;
            bit_cnt    <= '0;
            frame_done <= 1'b0;
`ifdef SERIAL_TX_PARITY_EN
            par_bit    <= 1'b0;
`endif
        end else begin
            state      <= state_n;
            shreg      <= shreg_n;
            bit_cnt    <= bit_cnt_n;
            frame_done <= done_n;
`ifdef SERIAL_TX_PARITY_EN
            par_bit    <= par_bit_n;
`endif
        end
    end

    // tx is decoded from registered state only, so an async reset forces the
    // line high without waiting for a clock edge.
    always_comb begin
        state_n   = state;
        shreg_n   = shreg;
        bit_cnt_n = bit_cnt;
        done_n    = 1'b0;
        tx        = 1'b1;
`ifdef SERIAL_TX_PARITY_EN
        par_bit_n = par_bit;
`endif
        case (state)
            IDLE: begin
                if (tx_valid) begin
                    shreg_n   = tx_data;
                    bit_cnt_n = '0;
                    state_n   = START;
`ifdef SERIAL_TX_PARITY_EN
                    // Parity taken from the word as accepted; the shift
                    // register no longer holds it by the PARITY state.
                    par_bit_n = (PARITY_ODD != 0) ? ~^tx_data : ^tx_data;
`endif
                end
            end
            START: begin
                tx = 1'b0;
                if (bit_tick) begin
                    state_n = DATA;
                end
            end
            DATA: begin
                tx = data_bit;
                if (bit_tick) begin
                    shreg_n = (LSB_FIRST != 0) ? (shreg >> 1) : (shreg << 1);
                    if (bit_cnt == LAST_BIT) begin
                        bit_cnt_n = '0;
`ifdef SERIAL_TX_PARITY_EN
                        state_n   = PARITY;
`else
                        state_n   = STOP;
`endif
                    end else begin
                        bit_cnt_n = bit_cnt + BW'(1);
                    end
                end
            end
`ifdef SERIAL_TX_PARITY_EN
            PARITY: begin
                tx = par_bit;
                if (bit_tick) begin
                    state_n = STOP;
                end
            end
`endif
            STOP: begin
                // bit_cnt is reused to count stop bits.
                if (bit_tick) begin
                    if (bit_cnt == LAST_STOP) begin
                        bit_cnt_n = '0;
                        state_n   = IDLE;
                        done_n    = 1'b1;
                    end else begin
                        bit_cnt_n = bit_cnt + BW'(1);
                    end
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

endmodule
